// File: rtl/test_harness_ctrl.sv
// Test harness controller: runs a DUT until completion or timeout, drives timed
// interrupt pulses, then streams the DUT register file out over a valid/ready port.
`timescale 1ns/1ps
module test_harness_ctrl #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned NREG       = 32,
  parameter int unsigned NIRQ       = 4,
  parameter int unsigned CW         = 32,
  parameter int unsigned MAX_CYCLES = 100000,
  localparam int unsigned AW        = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              completed,
  input  logic [NIRQ*CW-1:0] irq_at,
  input  logic [NIRQ*8-1:0]  irq_len,
  output logic              cpu_rstn,
  output logic              cpu_hold,
  output logic [NIRQ-1:0]   irq,
  output logic [AW-1:0]     rf_addr,
  input  logic [XLEN-1:0]   rf_data,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [AW-1:0]     dump_idx,
  output logic [XLEN-1:0]   dump_data,
  output logic [CW-1:0]     cycles,
  output logic              done,
  output logic              timeout
);

  if (64'(MAX_CYCLES) >= (64'd1 << CW)) begin : g_bad_max_cycles
    $error("MAX_CYCLES must be below 2**CW");
  end

  localparam logic [CW-1:0] LAST_CYC = CW'(MAX_CYCLES - 1);
  localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

  typedef enum logic [2:0] {IDLE, RUN, LOAD, SEND, DONE} state_t;

  state_t                state, state_nxt;
  logic [NIRQ*CW-1:0]    at_q;
  logic [NIRQ*8-1:0]     len_q;
  logic [AW-1:0]         idx;
  logic                  run_end;

  // Window test in CW+1 bits so at+len never wraps past the counter range.
  function automatic logic [NIRQ-1:0] irq_hit(input logic [NIRQ*CW-1:0] at,
                                              input logic [NIRQ*8-1:0]  len,
                                              input logic [CW-1:0]      c);
    logic [NIRQ-1:0] hit;
    logic [CW:0]     lo, hi, cx;
    hit = '0;
    cx  = {1'b0, c};
    for (int unsigned i = 0; i < NIRQ; i++) begin
      lo     = {1'b0, at[i*CW +: CW]};
      hi     = lo + (CW+1)'(len[i*8 +: 8]);
      hit[i] = (cx >= lo) && (cx < hi);
    end
    return hit;
  endfunction

  assign run_end = completed || (cycles == LAST_CYC);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN:  if (run_end) state_nxt = LOAD;
      LOAD: state_nxt = SEND;
      SEND: if (dump_ready) state_nxt = (idx == LAST_IDX) ? DONE : LOAD;
      DONE: if (start) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cycles    <= '0;
      timeout   <= 1'b0;
      irq       <= '0;
      idx       <= '0;
      dump_data <= '0;
      dump_idx  <= '0;
      at_q      <= '0;
      len_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          cycles  <= '0;
          timeout <= 1'b0;
          idx     <= '0;
          irq     <= '0;
          if (start) begin
            at_q  <= irq_at;
            len_q <= irq_len;
            // irq is registered, so the first RUN cycle's value comes from the live config.
            irq   <= irq_hit(irq_at, irq_len, '0);
          end
        end
        RUN: begin
          if (run_end) begin
            timeout <= !completed;
            irq     <= '0;
          end else begin
            cycles <= cycles + CW'(1);
            irq    <= irq_hit(at_q, len_q, cycles + CW'(1));
          end
        end
        LOAD: begin
          dump_data <= rf_data;
          dump_idx  <= idx;
        end
        SEND: begin
          if (dump_ready && (idx != LAST_IDX)) idx <= idx + AW'(1);
        end
        DONE: begin
          if (start) begin
            cycles  <= '0;
            timeout <= 1'b0;
            idx     <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign cpu_rstn   = (state != IDLE);
  assign cpu_hold   = (state == LOAD) || (state == SEND) || (state == DONE);
  assign dump_valid = (state == SEND);
  assign done       = (state == DONE);
  assign rf_addr    = idx;

endmodule

// File: tb/tb_test_harness_ctrl.sv
// Directed-plus-random bench for test_harness_ctrl with a cycle-level reference
// model of run length, interrupt windows and the register dump stream.
`timescale 1ns/1ps
module tb_test_harness_ctrl;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NIRQ = 4;
  localparam int CW   = 32;
  localparam int MAXC = 1000;
  localparam int AW   = $clog2(NREG);

  logic              clk = 1'b0;
  logic              rstn;
  logic              start;
  logic              completed;
  logic [NIRQ*CW-1:0] irq_at;
  logic [NIRQ*8-1:0]  irq_len;
  logic              cpu_rstn;
  logic              cpu_hold;
  logic [NIRQ-1:0]   irq;
  logic [AW-1:0]     rf_addr;
  logic [XLEN-1:0]   rf_data;
  logic              dump_valid;
  logic              dump_ready;
  logic [AW-1:0]     dump_idx;
  logic [XLEN-1:0]   dump_data;
  logic [CW-1:0]     cycles;
  logic              done;
  logic              timeout;

  logic [XLEN-1:0]   regs [NREG];
  int                cfg_at [NIRQ];
  int                cfg_len [NIRQ];
  int                lat_at [NIRQ];
  int                lat_len [NIRQ];
  int                exp_fin;
  bit                exp_to;
  int                checks = 0;
  int                errors = 0;

  test_harness_ctrl #(
    .XLEN(XLEN), .NREG(NREG), .NIRQ(NIRQ), .CW(CW), .MAX_CYCLES(MAXC)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .completed(completed),
    .irq_at(irq_at), .irq_len(irq_len), .cpu_rstn(cpu_rstn), .cpu_hold(cpu_hold),
    .irq(irq), .rf_addr(rf_addr), .rf_data(rf_data), .dump_valid(dump_valid),
    .dump_ready(dump_ready), .dump_idx(dump_idx), .dump_data(dump_data),
    .cycles(cycles), .done(done), .timeout(timeout)
  );

  always #5 clk = ~clk;

  assign rf_data = regs[rf_addr];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Channel i is asserted during run cycle k when k lies in [at, at+len).
  function automatic logic [NIRQ-1:0] model_irq(input int k);
    logic [NIRQ-1:0] r;
    r = '0;
    for (int i = 0; i < NIRQ; i++)
      r[i] = (lat_len[i] != 0) && (longint'(k) >= longint'(lat_at[i])) &&
             (longint'(k) < longint'(lat_at[i]) + longint'(lat_len[i]));
    return r;
  endfunction

  task automatic drive_cfg();
    for (int i = 0; i < NIRQ; i++) begin
      irq_at[i*CW +: CW] = cfg_at[i];
      irq_len[i*8 +: 8]  = cfg_len[i][7:0];
    end
  endtask

  task automatic rand_cfg();
    for (int i = 0; i < NIRQ; i++) begin
      cfg_at[i]  = $urandom_range(0, 400);
      cfg_len[i] = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 255);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_cpu_rstn"}, cpu_rstn, 0);
    chk({tag, "_cpu_hold"}, cpu_hold, 0);
    chk({tag, "_irq"}, irq, 0);
    chk({tag, "_cycles"}, cycles, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_timeout"}, timeout, 0);
    chk({tag, "_dump_valid"}, dump_valid, 0);
  endtask

  // Called at a negedge with the DUT in IDLE; returns at the LOAD-cycle negedge.
  task automatic run_phase(input int stop_at);
    int k;
    bit fin;
    check_idle("pre_run");
    for (int i = 0; i < NIRQ; i++) begin
      lat_at[i]  = cfg_at[i];
      lat_len[i] = cfg_len[i];
    end
    for (int r = 0; r < NREG; r++) regs[r] = $urandom;
    drive_cfg();
    exp_to  = !(stop_at >= 0 && stop_at < MAXC);
    exp_fin = exp_to ? MAXC - 1 : stop_at;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    fin = 0;
    while (!fin) begin
      chk("run_cycles", cycles, k);
      chk("run_cpu_rstn", cpu_rstn, 1);
      chk("run_cpu_hold", cpu_hold, 0);
      chk("run_valid", dump_valid, 0);
      chk("run_irq", irq, model_irq(k));
      irq_at    = {$urandom, $urandom, $urandom, $urandom};
      irq_len   = $urandom;
      start     = $urandom_range(0, 1);
      completed = (k == stop_at);
      fin       = (k == exp_fin);
      k++;
      @(negedge clk);
    end
    start     = 1'b0;
    completed = 1'b0;
    chk("load_cycles", cycles, exp_fin);
    chk("load_timeout", timeout, exp_to);
    chk("load_irq", irq, 0);
    chk("load_cpu_hold", cpu_hold, 1);
    chk("load_cpu_rstn", cpu_rstn, 1);
    chk("load_valid", dump_valid, 0);
  endtask

  // Accepts nwords words; returns at the negedge on which the last handshake is set up.
  task automatic dump_phase(input bit rand_ready, input int nwords);
    int  got = 0, budget = 0;
    bit  holding = 0, first = 1, just_xfer = 0;
    logic [XLEN-1:0] h_data;
    logic [AW-1:0]   h_idx;
    while (got < nwords && budget < 4000) begin
      @(negedge clk);
      budget++;
      start     = $urandom_range(0, 1);
      completed = $urandom_range(0, 1);
      chk("dump_cycles", cycles, exp_fin);
      chk("dump_irq", irq, 0);
      chk("dump_cpu_hold", cpu_hold, 1);
      if (first) chk("dump_first_valid", dump_valid, 1);
      if (just_xfer) chk("dump_gap", dump_valid, 0);
      first = 0;
      just_xfer = 0;
      if (dump_valid) begin
        if (!holding) begin
          chk("dump_idx", dump_idx, got);
          chk("dump_data", dump_data, regs[got]);
          h_data  = dump_data;
          h_idx   = dump_idx;
          holding = 1;
        end else begin
          chk("stall_idx", dump_idx, h_idx);
          chk("stall_data", dump_data, h_data);
        end
      end else if (holding) begin
        chk("valid_dropped", dump_valid, 1);
        holding = 0;
      end
      dump_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (dump_valid && dump_ready) begin
        got++;
        holding   = 0;
        just_xfer = 1;
      end
    end
    if (got < nwords) chk("dump_budget", got, nwords);
  endtask

  task automatic finish_phase();
    @(negedge clk);
    start = 1'b0; completed = 1'b0; dump_ready = 1'b0;
    chk("done_flag", done, 1);
    chk("done_valid", dump_valid, 0);
    chk("done_cpu_hold", cpu_hold, 1);
    chk("done_cpu_rstn", cpu_rstn, 1);
    chk("done_cycles", cycles, exp_fin);
    chk("done_timeout", timeout, exp_to);
    completed = 1'b1;
    @(negedge clk);
    completed = 1'b0;
    chk("done_hold", done, 1);
    chk("done_hold_cycles", cycles, exp_fin);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_idle("after_done");
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; completed = 1'b0; dump_ready = 1'b0;
    irq_at = '0; irq_len = '0;
    for (int r = 0; r < NREG; r++) regs[r] = $urandom;
    repeat (2) @(negedge clk);
    check_idle("reset");
    chk("reset_rf_addr", rf_addr, 0);
    chk("reset_dump_idx", dump_idx, 0);
    chk("reset_dump_data", dump_data, 0);
    rstn = 1'b1;
    @(negedge clk);

    // Completion at cycle 50, always-ready sink.
    rand_cfg();
    run_phase(50);
    dump_phase(0, NREG);
    finish_phase();

    // Single-cycle pulse on channel 0 at cycle 200, other channels disabled.
    rand_cfg();
    cfg_at[0] = 200; cfg_len[0] = 1;
    for (int i = 1; i < NIRQ; i++) cfg_len[i] = 0;
    run_phase(260);
    dump_phase(1, NREG);
    finish_phase();

    // Timeout with completed never asserted.
    rand_cfg();
    run_phase(-1);
    dump_phase(1, NREG);
    finish_phase();

    // Completion coinciding with the timeout cycle.
    rand_cfg();
    run_phase(MAXC - 1);
    dump_phase(1, NREG);
    finish_phase();

    // Reset asserted while a word is being offered.
    rand_cfg();
    run_phase(30);
    dump_phase(0, 5);
    @(negedge clk);
    start = 1'b0; completed = 1'b0;
    chk("rst_load_valid", dump_valid, 0);
    @(negedge clk);
    chk("rst_send_valid", dump_valid, 1);
    rstn = 1'b0;
    #1;
    check_idle("async_rst");
    chk("async_rst_rf_addr", rf_addr, 0);
    chk("async_rst_dump_idx", dump_idx, 0);
    chk("async_rst_dump_data", dump_data, 0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_valid", dump_valid, 0);
      chk("post_rst_cpu_rstn", cpu_rstn, 0);
    end
    rand_cfg();
    run_phase(40);
    dump_phase(1, NREG);
    finish_phase();

    // Randomized runs.
    for (int n = 0; n < 3; n++) begin
      rand_cfg();
      run_phase($urandom_range(0, 600));
      dump_phase(1, NREG);
      finish_phase();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
